// File: rtl/inv_qsn_pkg.sv
// Shared constants, payload types and ring-rotation helper for the inverse QSN pipe.
// Optional feature macro (consumed by inv_qsn_pipe_85b): INV_QSN_RANGE_CHK_EN.
package inv_qsn_pkg;

  localparam int unsigned CHECK_PARALLELISM     = 85;
  localparam int unsigned Z                     = CHECK_PARALLELISM;
  localparam int unsigned QUAN_SIZE             = 4;
  localparam int unsigned BITWIDTH_SHIFT_FACTOR = $clog2(CHECK_PARALLELISM - 1);
  localparam int unsigned TAG_WIDTH             = 8;

  // Shift bits [3:0] are handled in stage 1, the remaining bits in stage 2.
  localparam int unsigned LO_BITS = 4;
  localparam int unsigned HI_BITS = BITWIDTH_SHIFT_FACTOR - LO_BITS;

  // Ring rotation contributed by each shift bit: 2^b mod Z.
  localparam int unsigned ROT_AMT [BITWIDTH_SHIFT_FACTOR] = '{
    (1 << 0) % Z, (1 << 1) % Z, (1 << 2) % Z, (1 << 3) % Z,
    (1 << 4) % Z, (1 << 5) % Z, (1 << 6) % Z
  };

  typedef logic [Z-1:0]             plane_t;
  typedef plane_t [QUAN_SIZE-1:0]   planes_t;

  typedef struct packed {
    planes_t              planes;
    logic [HI_BITS-1:0]   shift_hi;
    logic [TAG_WIDTH-1:0] tag;
    logic                 err;
  } stage1_t;

  typedef struct packed {
    planes_t              planes;
    logic [TAG_WIDTH-1:0] tag;
    logic                 err;
  } stage2_t;

  // out[i] = x[(i + a) mod Z]: rotate toward index 0 around the Z-ring.
  function automatic plane_t rotr(input plane_t x, input int unsigned a);
    if (a == 0) return x;
    return (x >> a) | (x << (Z - a));
  endfunction

endpackage

// File: rtl/inv_qsn_pipe_85b_if.sv
// Stream interface of the inverse QSN pipe: input vector handshake and output vector handshake.
// master: the environment (drives in_*, out_ready); slave: the shifter block.
interface inv_qsn_pipe_85b_if;
  import inv_qsn_pkg::*;

  logic                             in_valid;
  logic                             in_ready;
  logic [Z-1:0]                     in_bit0;
  logic [Z-1:0]                     in_bit1;
  logic [Z-1:0]                     in_bit2;
  logic [Z-1:0]                     in_bit3;
  logic [BITWIDTH_SHIFT_FACTOR-1:0] in_shift;
  logic [TAG_WIDTH-1:0]             in_tag;

  logic                             out_valid;
  logic                             out_ready;
  logic [Z-1:0]                     out_bit0;
  logic [Z-1:0]                     out_bit1;
  logic [Z-1:0]                     out_bit2;
  logic [Z-1:0]                     out_bit3;
  logic [TAG_WIDTH-1:0]             out_tag;
  logic                             range_err;

  modport master (
    output in_valid, in_bit0, in_bit1, in_bit2, in_bit3, in_shift, in_tag, out_ready,
    input  in_ready, out_valid, out_bit0, out_bit1, out_bit2, out_bit3, out_tag, range_err
  );

  modport slave (
    input  in_valid, in_bit0, in_bit1, in_bit2, in_bit3, in_shift, in_tag, out_ready,
    output in_ready, out_valid, out_bit0, out_bit1, out_bit2, out_bit3, out_tag, range_err
  );

endinterface

// File: rtl/inv_qsn_rot_stage.sv
// Combinational ring rotation of all planes by the shift bits LO..HI (bit b rotates by 2^b mod Z).
// Ports: sel - shift bits LO..HI; din - input planes; dout_c - rotated planes.
module inv_qsn_rot_stage
  import inv_qsn_pkg::*;
#(
  parameter int unsigned LO = 0,
  parameter int unsigned HI = 3
) (
  input  logic [HI-LO:0] sel,
  input  planes_t        din,
  output planes_t        dout_c
);

  // Rotations compose additively mod Z, so each selected bit is applied in turn.
  always_comb begin
    dout_c = din;
    for (int unsigned b = LO; b <= HI; b++) begin
      if (sel[b-LO]) begin
        for (int k = 0; k < QUAN_SIZE; k++) begin
          dout_c[k] = rotr(dout_c[k], ROT_AMT[b]);
        end
      end
    end
  end

endmodule

// File: rtl/inv_qsn_pipe_85b.sv
// Two-stage pipelined inverse quasi-cyclic shifter: out_bitk[i] = in_bitk[(i + s) mod 85].
// Ports: sys_clk, rst (sync, active high); bus (slave) carries the valid/ready input and
// output vector streams, shift factor, side tag and range_err.
// Macro INV_QSN_RANGE_CHK_EN: when defined, s >= 85 yields zero planes with range_err=1;
// otherwise s >= 85 is folded to s - 85 and range_err stays 0.
module inv_qsn_pipe_85b
  import inv_qsn_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 rst,
  inv_qsn_pipe_85b_if.slave    bus
);

  localparam int unsigned SW = BITWIDTH_SHIFT_FACTOR;

  logic    v1, v2;
  logic    load1_c, load2_c;
  stage1_t s1;
  stage2_t s2;

  logic [SW-1:0] eff_c;
  logic          err_c;
  planes_t       in_planes_c, rot_lo_c, rot_hi_c;

  // Per-stage flow control: a stage loads when empty or when its contents move on.
  assign load2_c     = !v2 || bus.out_ready;
  assign load1_c     = !v1 || load2_c;
  assign bus.in_ready = load1_c;

  // Effective shift and out-of-range handling.
  always_comb begin
    in_planes_c = {bus.in_bit3, bus.in_bit2, bus.in_bit1, bus.in_bit0};
    eff_c       = bus.in_shift;
    err_c       = 1'b0;
    if (bus.in_shift >= SW'(Z)) begin
`ifdef INV_QSN_RANGE_CHK_EN
      in_planes_c = '0;
      eff_c       = '0;
      err_c       = 1'b1;
`else
      // s <= 127 < 2Z, so a single subtract lands in range.
      eff_c       = bus.in_shift - SW'(Z);
`endif
    end
  end

  inv_qsn_rot_stage #(.LO(0), .HI(LO_BITS - 1)) u_rot_lo (
    .sel    (eff_c[LO_BITS-1:0]),
    .din    (in_planes_c),
    .dout_c (rot_lo_c)
  );

  inv_qsn_rot_stage #(.LO(LO_BITS), .HI(SW - 1)) u_rot_hi (
    .sel    (s1.shift_hi),
    .din    (s1.planes),
    .dout_c (rot_hi_c)
  );

  // Pipeline registers; payload only updates when a valid vector moves in.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (load1_c) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          s1.planes   <= rot_lo_c;
          s1.shift_hi <= eff_c[SW-1:LO_BITS];
          s1.tag      <= bus.in_tag;
          s1.err      <= err_c;
        end
      end
      if (load2_c) begin
        v2 <= v1;
        if (v1) begin
          s2.planes <= rot_hi_c;
          s2.tag    <= s1.tag;
          s2.err    <= s1.err;
        end
      end
    end
  end

  assign bus.out_valid = v2;
  assign bus.out_bit0  = s2.planes[0];
  assign bus.out_bit1  = s2.planes[1];
  assign bus.out_bit2  = s2.planes[2];
  assign bus.out_bit3  = s2.planes[3];
  assign bus.out_tag   = s2.tag;
  assign bus.range_err = s2.err;

endmodule

// File: tb/tb_inv_qsn_pipe_85b.sv
// Directed bench for inv_qsn_pipe_85b: identity, wrap, multi-bit shift, range handling,
// backpressure, mid-flight reset and a randomized round trip through a forward QSN model.
module tb_inv_qsn_pipe_85b;
  import inv_qsn_pkg::*;

  localparam int unsigned VW = QUAN_SIZE * Z + TAG_WIDTH + 1;
  localparam int          N_RT = 1000;
  localparam int          RT_LIMIT = 20000;

`ifdef INV_QSN_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  inv_qsn_pipe_85b_if bus ();

  inv_qsn_pipe_85b dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_vec(input string name, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  function automatic plane_t oh(input int n);
    plane_t r;
    r    = '0;
    r[n] = 1'b1;
    return r;
  endfunction

  function automatic logic [VW-1:0] mk(input plane_t p3, input plane_t p2, input plane_t p1,
                                       input plane_t p0, input logic [TAG_WIDTH-1:0] tag,
                                       input logic err);
    return {p3, p2, p1, p0, tag, err};
  endfunction

  function automatic logic [VW-1:0] cur_out();
    return {bus.out_bit3, bus.out_bit2, bus.out_bit1, bus.out_bit0, bus.out_tag, bus.range_err};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input plane_t p0, input plane_t p1, input plane_t p2, input plane_t p3,
                       input logic [BITWIDTH_SHIFT_FACTOR-1:0] s, input logic [TAG_WIDTH-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_bit0  = p0;
    bus.in_bit1  = p1;
    bus.in_bit2  = p2;
    bus.in_bit3  = p3;
    bus.in_shift = s;
    bus.in_tag   = tag;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // One vector through an empty pipe with out_ready high: visible exactly one edge after accept.
  task automatic single(input string name, input plane_t p0, input plane_t p1, input plane_t p2,
                        input plane_t p3, input logic [BITWIDTH_SHIFT_FACTOR-1:0] s,
                        input logic [TAG_WIDTH-1:0] tag, input plane_t e0, input plane_t e1,
                        input plane_t e2, input plane_t e3, input logic eerr);
    drive(p0, p1, p2, p3, s, tag);
    check_bit({name, "_rdy"}, bus.in_ready, 1'b1);
    tick();
    idle();
    check_bit({name, "_lat1"}, bus.out_valid, 1'b0);
    tick();
    check_bit({name, "_vld"}, bus.out_valid, 1'b1);
    check_vec(name, cur_out(), mk(e3, e2, e1, e0, tag, eerr));
    tick();
    check_bit({name, "_drain"}, bus.out_valid, 1'b0);
  endtask

  plane_t                           src [QUAN_SIZE];
  plane_t                           fwd [QUAN_SIZE];
  logic [BITWIDTH_SHIFT_FACTOR-1:0] rt_s;
  logic [TAG_WIDTH-1:0]             rt_tag;
  logic [VW-1:0]                    rt_exp;
  logic [VW-1:0]                    exp_q [$];

  // Random source vector, forward-permuted: fwd[(j+s) mod Z] = src[j].
  task automatic gen_rt();
    rt_s   = BITWIDTH_SHIFT_FACTOR'($urandom_range(0, Z - 1));
    rt_tag = TAG_WIDTH'($urandom);
    for (int k = 0; k < QUAN_SIZE; k++) begin
      src[k] = plane_t'({$urandom, $urandom, $urandom});
      for (int j = 0; j < Z; j++) fwd[k][(j + int'(rt_s)) % Z] = src[k][j];
    end
    rt_exp = mk(src[3], src[2], src[1], src[0], rt_tag, 1'b0);
    drive(fwd[0], fwd[1], fwd[2], fwd[3], rt_s, rt_tag);
  endtask

  initial begin
    int  sent;
    int  got;
    int  cyc;
    logic acc;
    logic pop;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit0   = '0;
    bus.in_bit1   = '0;
    bus.in_bit2   = '0;
    bus.in_bit3   = '0;
    bus.in_shift  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_vec("rst_out", cur_out(), '0);

    single("identity", oh(0), '0, '0, '0, 7'd0, 8'h5A, oh(0), '0, '0, '0, 1'b0);
    single("wrap_s1", oh(0), oh(5), oh(84), oh(40), 7'd1, 8'h11,
           oh(84), oh(4), oh(83), oh(39), 1'b0);
    single("wrap_s84", oh(0), oh(5), oh(84), oh(40), 7'd84, 8'h22,
           oh(1), oh(6), oh(0), oh(41), 1'b0);
    single("multi_s37", oh(0) | oh(1), oh(5), oh(84), oh(40), 7'd37, 8'h33,
           oh(48) | oh(49), oh(53), oh(47), oh(3), 1'b0);
    single("s15", oh(0), oh(5), oh(84), oh(40), 7'd15, 8'h44,
           oh(70), oh(75), oh(69), oh(25), 1'b0);
    if (RANGE_CHK)
      single("range_s100", oh(0), oh(5), oh(84), oh(40), 7'd100, 8'h55,
             '0, '0, '0, '0, 1'b1);
    else
      single("range_s100", oh(0), oh(5), oh(84), oh(40), 7'd100, 8'h55,
             oh(70), oh(75), oh(69), oh(25), 1'b0);

    // Backpressure: three back-to-back vectors with out_ready low for five edges.
    bus.out_ready = 1'b0;
    drive(oh(10), '0, '0, '0, 7'd1, 8'hA1);
    check_bit("bp_rdy_a", bus.in_ready, 1'b1);
    tick();
    drive(oh(20), '0, '0, '0, 7'd1, 8'hA2);
    check_bit("bp_rdy_b", bus.in_ready, 1'b1);
    tick();
    drive(oh(30), '0, '0, '0, 7'd1, 8'hA3);
    check_bit("bp_full_rdy", bus.in_ready, 1'b0);
    check_bit("bp_full_vld", bus.out_valid, 1'b1);
    check_vec("bp_hold_a0", cur_out(), mk('0, '0, '0, oh(9), 8'hA1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit("bp_stall_rdy", bus.in_ready, 1'b0);
      check_vec("bp_hold_a", cur_out(), mk('0, '0, '0, oh(9), 8'hA1, 1'b0));
    end
    bus.out_ready = 1'b1;
    #1;
    check_bit("bp_resume_rdy", bus.in_ready, 1'b1);
    tick();
    idle();
    check_bit("bp_b_vld", bus.out_valid, 1'b1);
    check_vec("bp_b", cur_out(), mk('0, '0, '0, oh(19), 8'hA2, 1'b0));
    tick();
    check_bit("bp_c_vld", bus.out_valid, 1'b1);
    check_vec("bp_c", cur_out(), mk('0, '0, '0, oh(29), 8'hA3, 1'b0));
    tick();
    check_bit("bp_empty", bus.out_valid, 1'b0);

    // Reset with two vectors in flight.
    drive(oh(2), '0, '0, '0, 7'd0, 8'hB1);
    tick();
    drive(oh(3), '0, '0, '0, 7'd0, 8'hB2);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bit("mrst_vld", bus.out_valid, 1'b0);
    check_bit("mrst_rdy", bus.in_ready, 1'b1);
    check_vec("mrst_out", cur_out(), '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit("mrst_ghost", bus.out_valid, 1'b0);
    end

    // Round trip: forward-permuted random vectors must return to natural order.
    sent = 0;
    got  = 0;
    cyc  = 0;
    gen_rt();
    while (got < N_RT && cyc < RT_LIMIT) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      if (pop) begin
        if (exp_q.size() == 0) check_bit("rt_ghost", bus.out_valid, 1'b0);
        else check_vec("rt_data", cur_out(), exp_q.pop_front());
        got++;
      end
      if (acc) exp_q.push_back(rt_exp);
      @(posedge sys_clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < N_RT) gen_rt();
        else idle();
      end
    end
    check_bit("rt_timeout", cyc < RT_LIMIT, 1'b1);
    check_bit("rt_count", got == N_RT, 1'b1);
    check_bit("rt_q_empty", exp_q.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_qsn_pipe_85b.md
# inv_qsn_pipe_85b

Pipelined inverse quasi-cyclic shifter for the 4-bit-plane message path of the 85-wide layered decoder. It undoes the cyclic permutation applied by the forward QSN network, returning messages to their natural column order before write-back to the variable-node memories. It accepts one 4-plane vector per cycle under valid/ready flow control and carries a side tag alongside the data. It sits between the CNU output and the VN memory write port, the opposite end of the forward shifter.

## Interface
- CHECK_PARALLELISM, 85, ring length Z (bits per plane)
- QUAN_SIZE, 4, number of bit-planes
- BITWIDTH_SHIFT_FACTOR, $clog2(CHECK_PARALLELISM-1) (=7), shift-factor width
- TAG_WIDTH, 8, side-band tag width (layer/column index)

Ports:
- sys_clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept this cycle
- in_bit0..in_bit3  in  CHECK_PARALLELISM each  permuted bit-planes
- in_shift  in  BITWIDTH_SHIFT_FACTOR  forward shift factor s applied upstream
- in_tag  in  TAG_WIDTH  passed through unmodified
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts
- out_bit0..out_bit3  out  CHECK_PARALLELISM each  de-permuted planes
- out_tag  out  TAG_WIDTH  tag of the output vector
- range_err  out  1  qualified by out_valid; in_shift was ≥ Z

## Operation
- Function per plane k: out_bitk[i] = in_bitk[(i + s) mod Z], i = 0..Z-1. This inverts the forward mapping in[j] → position (j+s) mod Z.
- Effective shift e: if s < Z, then e = s. Otherwise handling depends on the Configuration macro.
- Rotation is a log shifter over the Z-ring. Bit b of e rotates by (2^b mod Z). Rotations compose additively mod Z.
- Stage 1 register captures data rotated by e[3:0] (combinational in front of the register), plus e[6:4], tag and err.
- Stage 2 register captures the stage-1 data rotated by e[6:4], plus tag and err. Stage 2 drives the outputs directly.
- Flow control per stage: valid bit v1, v2.
  - Stage 2 loads when !v2 | out_ready.
  - Stage 1 loads when !v1 | stage-2 load.
  - in_ready = !v1 | stage-2 load.
- Sustained throughput is 1 vector/cycle.
- Outputs (data, tag, range_err) hold stable while out_valid & !out_ready.
- Order is strictly preserved; no vector is dropped or duplicated.

## Timing
- Latency: a vector accepted at edge N appears with out_valid=1 after edge N+1 (2 register stages).
- Reset values: out_valid=0, out_bit0..3=0, out_tag=0, range_err=0, internal valids=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: all in-flight vectors are discarded. out_valid is 0 in the cycle after rst is sampled high. Nothing stale emerges after rst deasserts.
- Simultaneous output pop and input push with both stages full: all stages advance in the same edge with no bubble.
- out_ready low while the pipeline is full: in_ready=0. Accepts resume the same cycle out_ready returns high.
- s=0: identity. s=Z-1: out[i]=in[(i-1) mod Z] (wrap-around).

## Configuration
- INV_QSN_RANGE_CHK_EN defined, for s ≥ Z:
  - out planes are all zeros
  - range_err=1 with that vector
  - tag still passes through
- INV_QSN_RANGE_CHK_EN undefined:
  - e = s − Z; one conditional subtract suffices since s ≤ 127 < 2Z
  - range_err is tied to 0

## Structure
- Shared package inv_qsn_pkg holds:
  - Z, QUAN_SIZE, BITWIDTH_SHIFT_FACTOR
  - the per-bit rotation amounts (2^b mod Z) as a constant array
  - a plane-vector typedef
- One sub-module, inv_qsn_rot_stage: combinational ring rotation of QUAN_SIZE planes by a selected subset of shift bits, parameterised by the bit range. It is instantiated once per stage.

## Test plan
- Identity: s=0, in_bit0=85'h1, tag=8'h5A → out_bit0=85'h1, out_tag=8'h5A, exactly 2 cycles after accept.
- Wrap: s=1, in_bit0 has bit 0 set → out_bit0 has bit 84 set. Same vector with s=84 → bit 1 set. All four planes checked independently.
- Range: s=100.
  - With INV_QSN_RANGE_CHK_EN: out planes all zero, range_err=1.
  - Without it: result equals the s=15 response, range_err=0.
- Backpressure: 3 back-to-back vectors, out_ready held low 5 cycles → in_ready falls after 2 accepts. Outputs hold stable while stalled, then all 3 emerge in order once out_ready rises.
- Reset mid-flight: rst for 1 cycle with 2 vectors in flight → out_valid=0 next cycle, no ghost output, in_ready=1.
- Round-trip: 1000 random vectors and random s in 0..84 through a forward QSN model, then this block → exact match at full throughput with random out_ready.
